timer_tick_sequencer: RTL and testbench

TIMER_TICK_SEQUENCER -- requirements
Module: timer_tick_sequencer

---
 rtl/timer_pkg.sv | 43 ++++
 rtl/timer_tick_sequencer_tick_divider.sv | 47 ++++
 rtl/timer_tick_sequencer.sv | 105 ++++++++++
 tb/tb_timer_tick_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - timer slave register map, control bits and sequencer state encoding
package timer_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam logic [15:0] CTL_RUN_WORD  = 16'((1 << CTL_START) | (1 << CTL_CONT) | (1 << CTL_ITO));
  localparam logic [15:0] CTL_HALT_WORD = 16'(1 << CTL_STOP);
  localparam logic [15:0] STATUS_CLEAR_WORD = 16'h0000;

  typedef enum logic [2:0] {
    INIT_PL,
    INIT_PH,
    INIT_CTL,
    RUN,
    CLEAR,
    HALT,
    STOPPED
  } seq_state_e;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } tmr_bus_t;

  localparam tmr_bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'd0};

  function automatic tmr_bus_t bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_write = '{cs: 1'b1, write_n: 1'b0, addr: a, data: d};
  endfunction

endpackage

// File: rtl/timer_tick_sequencer_tick_divider.sv
// rtl/timer_tick_sequencer_tick_divider.sv - modulo-N tick divider with registered wrap strobe
module tick_divider
  import timer_pkg::*;
#(
  parameter int unsigned N = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  output logic strobe
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] count_q, count_d;
  logic         strobe_q, strobe_d;
  logic         at_last;

  assign at_last = (count_q == W'(N - 1));

  // strobe is registered on the same edge as the wrapping tick, so both appear together
  always_comb begin
    count_d  = count_q;
    strobe_d = 1'b0;
    if (tick) begin
      if (at_last) begin
        count_d  = '0;
        strobe_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/timer_tick_sequencer.sv
// rtl/timer_tick_sequencer.sv - programs an Avalon-MM interval timer and turns its timeouts into ticks
module timer_tick_sequencer
  import timer_pkg::*;
#(
  parameter logic [31:0] PERIOD           = 32'd49999,
  parameter int unsigned TICKS_PER_SAMPLE = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        irq,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  output logic        tick,
  output logic        sample_strobe,
  output logic [31:0] tick_count,
  output logic        running
);

  seq_state_e  state_q, state_d;
  logic        go_q;
  tmr_bus_t    bus_q, bus_d;
  logic        tick_q, tick_d;
  logic        running_q, running_d;
  logic [31:0] tick_count_q;

  // Outputs are registered from the next state so they line up with state_q; go_q holds
  // INIT_PL for the first edge after reset so its write is the first one seen on the bus.
  always_comb begin
    state_d = state_q;
    if (!go_q) begin
      state_d = INIT_PL;
    end else begin
      case (state_q)
        INIT_PL:  state_d = INIT_PH;
        INIT_PH:  state_d = INIT_CTL;
        INIT_CTL: state_d = RUN;
        RUN: begin
          if (irq)          state_d = CLEAR;
          else if (!enable) state_d = HALT;
        end
        CLEAR:    state_d = RUN;
        HALT:     state_d = STOPPED;
        STOPPED: begin
          if (irq)         state_d = CLEAR;
          else if (enable) state_d = INIT_CTL;
        end
        default:  state_d = INIT_PL;
      endcase
    end

    bus_d = BUS_IDLE;
    case (state_d)
      INIT_PL:  bus_d = bus_write(TMR_PERIODL, PERIOD[15:0]);
      INIT_PH:  bus_d = bus_write(TMR_PERIODH, PERIOD[31:16]);
      INIT_CTL: bus_d = bus_write(TMR_CONTROL, CTL_RUN_WORD);
      CLEAR:    bus_d = bus_write(TMR_STATUS, STATUS_CLEAR_WORD);
      HALT:     bus_d = bus_write(TMR_CONTROL, CTL_HALT_WORD);
      default:  bus_d = BUS_IDLE;
    endcase

    tick_d    = (state_d == CLEAR);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT_PL;
      go_q         <= 1'b0;
      bus_q        <= BUS_IDLE;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= 1'b1;
      bus_q     <= bus_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      if (tick_d) begin
        tick_count_q <= tick_count_q + 32'd1;
      end
    end
  end

  tick_divider #(
    .N(TICKS_PER_SAMPLE)
  ) u_tick_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick_d),
    .strobe (sample_strobe)
  );

  assign tmr_address    = bus_q.addr;
  assign tmr_chipselect = bus_q.cs;
  assign tmr_write_n    = bus_q.write_n;
  assign tmr_writedata  = bus_q.data;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign running        = running_q;

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// tb/tb_timer_tick_sequencer.sv - directed bench with a behavioural interval-timer slave
module tb_timer_tick_sequencer;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        irq;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tick;
  logic        sample_strobe;
  logic [31:0] tick_count;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  timer_tick_sequencer #(
    .PERIOD          (32'd9),
    .TICKS_PER_SAMPLE(3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .irq           (irq),
    .tmr_address   (tmr_address),
    .tmr_chipselect(tmr_chipselect),
    .tmr_write_n   (tmr_write_n),
    .tmr_writedata (tmr_writedata),
    .tick          (tick),
    .sample_strobe (sample_strobe),
    .tick_count    (tick_count),
    .running       (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Interval timer slave: continuous countdown, timeout flag cleared by a status write.
  logic [31:0] m_period;
  logic [31:0] m_cnt;
  logic        m_run;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_period <= 32'd0;
      m_cnt    <= 32'd0;
      m_run    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          irq   <= 1'b1;
          m_cnt <= m_period;
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: irq <= 1'b0;
          3'd1: begin
            if (tmr_writedata[3]) m_run <= 1'b0;
            else if (tmr_writedata[2]) begin
              m_run <= 1'b1;
              m_cnt <= m_period;
            end
          end
          3'd2: m_period[15:0]  <= tmr_writedata;
          3'd3: m_period[31:16] <= tmr_writedata;
          default: ;
        endcase
      end
    end
  end

  logic [20:0] bus_obs;
  assign bus_obs = {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};

  function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
    wr = {1'b1, 1'b0, a, d};
  endfunction

  localparam logic [20:0] IDLE = {1'b0, 1'b1, 3'd0, 16'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic next_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      next_neg();
      if (tick) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int n_tick;
    int n_strobe;
    int n_run;
    int at;

    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bus", 32'(bus_obs), 32'(IDLE));
    chk("rst_tick", 32'(tick), 0);
    chk("rst_strobe", 32'(sample_strobe), 0);
    chk("rst_count", tick_count, 0);
    chk("rst_running", 32'(running), 0);

    reset_n = 1'b1;
    next_neg();
    chk("init_pl", 32'(bus_obs), 32'(wr(3'd2, 16'h0009)));
    next_neg();
    chk("init_ph", 32'(bus_obs), 32'(wr(3'd3, 16'h0000)));
    next_neg();
    chk("init_ctl", 32'(bus_obs), 32'(wr(3'd1, 16'h0007)));
    chk("init_ctl_running", 32'(running), 0);
    next_neg();
    chk("run_cycle", cyc, 4);
    chk("run_running", 32'(running), 1);
    chk("run_bus_idle", 32'(bus_obs), 32'(IDLE));

    n_tick = 0;
    n_strobe = 0;
    for (int c = 4; c <= 103; c++) begin
      if (c > 4) next_neg();
      if (sample_strobe) n_strobe++;
      if (tick) begin
        n_tick++;
        chk("tick_cycle", cyc, 5 + 10 * n_tick);
        chk("tick_bus", 32'(bus_obs), 32'(wr(3'd0, 16'h0000)));
        chk("tick_count", tick_count, n_tick);
        chk("tick_strobe", 32'(sample_strobe), ((n_tick % 3) == 0) ? 1 : 0);
      end
    end
    chk("ticks_in_100", n_tick, 9);
    chk("strobes_in_100", n_strobe, 3);

    next_neg();
    next_neg();
    chk("tick10", 32'(tick), 1);
    chk("tick10_count", tick_count, 10);
    chk("tick10_strobe", 32'(sample_strobe), 0);
    next_neg();
    chk("pre_halt_running", 32'(running), 1);
    enable = 1'b0;
    next_neg();
    chk("halt_bus", 32'(bus_obs), 32'(wr(3'd1, 16'h0008)));
    chk("halt_running", 32'(running), 0);

    n_tick = 0;
    n_run = 0;
    for (int c = 0; c < 50; c++) begin
      next_neg();
      if (tick) n_tick++;
      if (running) n_run++;
    end
    chk("stopped_ticks", n_tick, 0);
    chk("stopped_running", n_run, 0);
    chk("stopped_bus", 32'(bus_obs), 32'(IDLE));

    next_neg();
    enable = 1'b1;
    next_neg();
    chk("restart_ctl", 32'(bus_obs), 32'(wr(3'd1, 16'h0007)));
    next_neg();
    chk("restart_running", 32'(running), 1);
    wait_tick(30, at);
    chk("resume_cycle", at, 171);
    chk("resume_count", tick_count, 11);
    chk("resume_strobe", 32'(sample_strobe), 0);

    while (cyc < 180) next_neg();
    enable = 1'b0;
    next_neg();
    chk("prio_tick", 32'(tick), 1);
    chk("prio_clear_bus", 32'(bus_obs), 32'(wr(3'd0, 16'h0000)));
    chk("prio_count", tick_count, 12);
    chk("prio_strobe", 32'(sample_strobe), 1);
    next_neg();
    chk("prio_run", 32'(running), 1);
    next_neg();
    chk("prio_halt_bus", 32'(bus_obs), 32'(wr(3'd1, 16'h0008)));

    next_neg();
    force dut.tick_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.tick_count_q;
    chk("wrap_preload", tick_count, 32'hFFFF_FFFF);
    enable = 1'b1;
    wait_tick(30, at);
    chk("wrap_cycle", at, 197);
    chk("wrap_count", tick_count, 0);
    chk("wrap_strobe", 32'(sample_strobe), 0);
    wait_tick(20, at);
    chk("wrap_next_count", tick_count, 1);
    chk("wrap_next_strobe", 32'(sample_strobe), 0);
    wait_tick(20, at);
    chk("wrap_div_count", tick_count, 2);
    chk("wrap_div_strobe", 32'(sample_strobe), 1);

    reset_n = 1'b0;
    next_neg();
    chk("rst2_count", tick_count, 0);
    chk("rst2_running", 32'(running), 0);
    reset_n = 1'b1;
    next_neg();
    next_neg();
    chk("abort_ph", 32'(bus_obs), 32'(wr(3'd3, 16'h0000)));
    reset_n = 1'b0;
    #1;
    chk("abort_idle", 32'(bus_obs), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    next_neg();
    chk("restart_pl", 32'(bus_obs), 32'(wr(3'd2, 16'h0009)));
    next_neg();
    chk("restart_ph", 32'(bus_obs), 32'(wr(3'd3, 16'h0000)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
